// File: rtl/vend_credit_controller.sv
// -----------------------------------------------------------------------------
// vend_credit_controller
//
// Credit and change-return sequencer for the vending machine. Coin levels from
// the coin accepter are synchronised and edge-detected, and each coin event
// adds its value to a saturating credit register. Purchase requests are
// granted or refused against that credit. A change-return request pays the
// credit back as a timed series of coin-return pulses, choosing the largest
// coin that still fits on each pulse.
//
// Ports
//   CLOCK_50      in   system clock, all state on the rising edge
//   reset         in   synchronous, active-high
//   circle        in   coin level, asynchronous, held for many cycles
//   triangle      in   coin level, asynchronous, held for many cycles
//   pentagon      in   coin level, asynchronous, held for many cycles
//   buy           in   one-cycle purchase request
//   price         in   item price, sampled with buy
//   coin_return   in   one-cycle change-return request
//   credit        out  current credit
//   dispense      out  one-cycle pulse, purchase granted
//   reject        out  one-cycle pulse, purchase refused
//   overflow      out  one-cycle pulse, coin value clipped at MAX_CREDIT
//   bad_coin      out  one-cycle pulse, coin vector was not one-hot
//   ret_circle    out  change-return drive, circle
//   ret_triangle  out  change-return drive, triangle
//   ret_pentagon  out  change-return drive, pentagon
//   busy          out  high whenever the controller is not idle
//   state_dbg     out  current FSM state (IDLE=0, RET_PULSE=1, RET_GAP=2)
//
// Request semantics: buy and coin_return are single-cycle strobes with no
// back-pressure. Every buy receives exactly one dispense or reject pulse in
// the following cycle; a coin_return is acted on only when idle with nonzero
// credit, and is otherwise dropped without a response.
// -----------------------------------------------------------------------------
module vend_credit_controller #(
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 255,
  parameter int VAL_CIRCLE   = 1,
  parameter int VAL_TRIANGLE = 3,
  parameter int VAL_PENTAGON = 5,
  parameter int PULSE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 25_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                circle,
  input  logic                triangle,
  input  logic                pentagon,
  input  logic                buy,
  input  logic [CREDIT_W-1:0] price,
  input  logic                coin_return,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                reject,
  output logic                overflow,
  output logic                bad_coin,
  output logic                ret_circle,
  output logic                ret_triangle,
  output logic                ret_pentagon,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  // The timer only ever holds (length - 1), so it needs to cover the longer
  // of the two phases minus one.
  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]    PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] V_CIRCLE   = CREDIT_W'(VAL_CIRCLE);
  localparam logic [CREDIT_W-1:0] V_TRIANGLE = CREDIT_W'(VAL_TRIANGLE);
  localparam logic [CREDIT_W-1:0] V_PENTAGON = CREDIT_W'(VAL_PENTAGON);
  localparam logic [CREDIT_W:0]   MAX_EXT    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] MAX_VAL    = CREDIT_W'(MAX_CREDIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RET_PULSE = 2'd1,
    RET_GAP   = 2'd2
  } state_t;

  state_t state;

  // Coin vector bit order: [0] circle, [1] triangle, [2] pentagon.
  logic [2:0]          coin_sync1;
  logic [2:0]          coin_sync2;
  logic [2:0]          coin_prev;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          ret_sel;

  logic                coin_event;
  logic                coin_onehot;
  logic                coin_good;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_ovf;
  logic [CREDIT_W-1:0] t_credit;
  logic                buy_ok;
  logic [CREDIT_W-1:0] after_buy;
  logic [2:0]          sel_idle;
  logic [2:0]          sel_live;

  // Largest denomination whose value fits in amt, as a one-hot {p, t, c}.
  // Written without assuming an ordering of the three values.
  function automatic logic [2:0] pick_denom(input logic [CREDIT_W-1:0] amt);
    logic [2:0]          sel;
    logic [CREDIT_W-1:0] best;
    sel  = 3'b000;
    best = '0;
    if (V_CIRCLE <= amt) begin
      sel  = 3'b001;
      best = V_CIRCLE;
    end
    if ((V_TRIANGLE <= amt) && (V_TRIANGLE > best)) begin
      sel  = 3'b010;
      best = V_TRIANGLE;
    end
    if ((V_PENTAGON <= amt) && (V_PENTAGON > best)) begin
      sel  = 3'b100;
    end
    return sel;
  endfunction

  function automatic logic [CREDIT_W-1:0] denom_value(input logic [2:0] sel);
    logic [CREDIT_W-1:0] v;
    case (sel)
      3'b001:  v = V_CIRCLE;
      3'b010:  v = V_TRIANGLE;
      3'b100:  v = V_PENTAGON;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    // One event per level episode: first nonzero sample after a zero sample.
    coin_event  = (coin_sync2 != 3'b000) && (coin_prev == 3'b000);
    coin_onehot = (coin_sync2 != 3'b000) &&
                  ((coin_sync2 & (coin_sync2 - 3'b001)) == 3'b000);
    coin_good   = coin_event && coin_onehot;

    coin_val = '0;
    if (coin_good) begin
      case (coin_sync2)
        3'b001:  coin_val = {1'b0, V_CIRCLE};
        3'b010:  coin_val = {1'b0, V_TRIANGLE};
        3'b100:  coin_val = {1'b0, V_PENTAGON};
        default: coin_val = '0;
      endcase
    end

    // One extra bit so the saturation test sees the carry.
    sum      = {1'b0, credit} + coin_val;
    coin_ovf = (sum > MAX_EXT);
    t_credit = coin_ovf ? MAX_VAL : sum[CREDIT_W-1:0];

    buy_ok    = (t_credit >= price);
    after_buy = (buy && buy_ok) ? (t_credit - price) : t_credit;

    // Idle start uses the post-purchase credit; re-entry from the gap uses
    // the live credit so coins inserted during the return are also paid out.
    sel_idle = pick_denom(after_buy);
    sel_live = pick_denom(t_credit);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      coin_sync1 <= 3'b000;
      coin_sync2 <= 3'b000;
      coin_prev  <= 3'b000;
      state      <= IDLE;
      credit     <= '0;
      cnt        <= '0;
      ret_sel    <= 3'b000;
      dispense   <= 1'b0;
      reject     <= 1'b0;
      overflow   <= 1'b0;
      bad_coin   <= 1'b0;
    end else begin
      coin_sync1 <= {pentagon, triangle, circle};
      coin_sync2 <= coin_sync1;
      coin_prev  <= coin_sync2;

      // Coin events are honoured in every state.
      overflow <= coin_good && coin_ovf;
      bad_coin <= coin_event && !coin_onehot;
      dispense <= 1'b0;
      reject   <= 1'b0;

      case (state)
        IDLE: begin
          credit <= after_buy;
          if (buy) begin
            dispense <= buy_ok;
            reject   <= !buy_ok;
          end
          if (coin_return && (after_buy != '0)) begin
            state   <= RET_PULSE;
            credit  <= after_buy - denom_value(sel_idle);
            ret_sel <= sel_idle;
            cnt     <= PULSE_LOAD;
          end
        end

        RET_PULSE: begin
          credit <= t_credit;
          reject <= buy;
          if (cnt == '0) begin
            state   <= RET_GAP;
            ret_sel <= 3'b000;
            cnt     <= GAP_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RET_GAP: begin
          reject <= buy;
          if (cnt == '0) begin
            if (t_credit == '0) begin
              state  <= IDLE;
              credit <= t_credit;
            end else begin
              // Greedy pick on t_credit, which never exceeds MAX_CREDIT and
              // always covers the chosen coin, so no underflow is possible.
              state   <= RET_PULSE;
              credit  <= t_credit - denom_value(sel_live);
              ret_sel <= sel_live;
              cnt     <= PULSE_LOAD;
            end
          end else begin
            credit <= t_credit;
            cnt    <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          ret_sel <= 3'b000;
        end
      endcase
    end
  end

  // ret_* come straight from flops, so they are glitch-free and mutually
  // exclusive by construction of the one-hot ret_sel.
  assign ret_circle   = ret_sel[0];
  assign ret_triangle = ret_sel[1];
  assign ret_pentagon = ret_sel[2];
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_vend_credit_controller.sv
// -----------------------------------------------------------------------------
// tb_vend_credit_controller
//
// Bench for vend_credit_controller with short return timing (4-cycle pulses,
// 2-cycle gaps). Directed scenes follow the coin / purchase / return /
// saturation / abort cases, then a randomised phase mixes all inputs.
// -----------------------------------------------------------------------------
module tb_vend_credit_controller;

  localparam int W    = 8;
  localparam int MAXC = 255;
  localparam int VC   = 1;
  localparam int VT   = 3;
  localparam int VP   = 5;
  localparam int PC   = 4;
  localparam int GC   = 2;

  // ---------------------------------------------------------------- clock/reset
  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         circle, triangle, pentagon;
  logic         buy, coin_return;
  logic [W-1:0] price;
  logic [W-1:0] credit;
  logic         dispense, reject, overflow, bad_coin;
  logic         ret_circle, ret_triangle, ret_pentagon, busy;
  logic [1:0]   state_dbg;

  always #10 CLOCK_50 = ~CLOCK_50;

  int edge_cnt = 0;
  always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 1;

  vend_credit_controller #(
    .CREDIT_W    (W),
    .MAX_CREDIT  (MAXC),
    .VAL_CIRCLE  (VC),
    .VAL_TRIANGLE(VT),
    .VAL_PENTAGON(VP),
    .PULSE_CYCLES(PC),
    .GAP_CYCLES  (GC)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .circle      (circle),
    .triangle    (triangle),
    .pentagon    (pentagon),
    .buy         (buy),
    .price       (price),
    .coin_return (coin_return),
    .credit      (credit),
    .dispense    (dispense),
    .reject      (reject),
    .overflow    (overflow),
    .bad_coin    (bad_coin),
    .ret_circle  (ret_circle),
    .ret_triangle(ret_triangle),
    .ret_pentagon(ret_pentagon),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ------------------------------------------------------------- scoreboard
  // Entry: {edge number, busy, ret_p, ret_t, ret_c, dispense, reject,
  //         overflow, bad_coin, credit}
  logic [47:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  logic [15:0] mon_last = 16'h0000;
  logic [47:0] exp_e;
  logic [15:0] dut_snap;

  assign dut_snap = {busy, ret_pentagon, ret_triangle, ret_circle,
                     dispense, reject, overflow, bad_coin, credit};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (mon_en && (dut_snap !== mon_last)) begin
      mon_last = dut_snap;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: edge %0d got %h, nothing expected", edge_cnt, dut_snap);
      end else begin
        exp_e = exp_q.pop_front();
        if ((exp_e[47:16] !== edge_cnt) || (exp_e[15:0] !== dut_snap)) begin
          n_fail++;
          $display("FAIL output_change: got edge %0d snap %h, expected edge %0d snap %h",
                   edge_cnt, dut_snap, exp_e[47:16], exp_e[15:0]);
        end
      end
      n_checks++;
      if ($countones({ret_pentagon, ret_triangle, ret_circle}) > 1) begin
        n_fail++;
        $display("FAIL ret_exclusive: got ret %b, required at most one high",
                 {ret_pentagon, ret_triangle, ret_circle});
      end
    end
  end

  // --------------------------------------------------------- reference model
  int          m_credit    = 0;
  bit          m_active    = 1'b0;
  int          m_denom     = 0;
  int          m_seg_start = 0;
  int          m_next_dec  = 0;
  logic [2:0]  m_h1 = 3'b000, m_h2 = 3'b000, m_h3 = 3'b000;  // inputs at e-1, e-2, e-3
  logic [15:0] m_last_snap = 16'h0000;

  function automatic int coin_value(input logic [2:0] v);
    case (v)
      3'b001:  return VC;
      3'b010:  return VT;
      3'b100:  return VP;
      default: return 0;
    endcase
  endfunction

  function automatic int greedy(input int c);
    if (c >= VP) return VP;
    if (c >= VT) return VT;
    return VC;
  endfunction

  task automatic start_return_coin(input int e, inout int t);
    m_denom     = greedy(t);
    t           = t - m_denom;
    m_seg_start = e;
    m_next_dec  = e + PC + GC;
    m_active    = 1'b1;
  endtask

  // Expected visible state after edge e given the inputs sampled at edge e.
  task automatic model_edge(input int e, input logic [2:0] cv, input logic b,
                            input int pr, input logic cr, input logic rs);
    int          t;
    logic        disp, rej, ovf, bad;
    logic [2:0]  rets;
    logic [15:0] snap;
    disp = 1'b0; rej = 1'b0; ovf = 1'b0; bad = 1'b0; rets = 3'b000;
    if (rs) begin
      m_credit = 0;
      m_active = 1'b0;
      m_h1 = 3'b000; m_h2 = 3'b000; m_h3 = 3'b000;
    end else begin
      t = m_credit;
      // A coin first sampled at edge n is credited at edge n+2.
      if ((m_h2 != 3'b000) && (m_h3 == 3'b000)) begin
        if ($countones(m_h2) != 1) bad = 1'b1;
        else begin
          t = t + coin_value(m_h2);
          if (t > MAXC) begin
            ovf = 1'b1;
            t   = MAXC;
          end
        end
      end
      if (!m_active) begin
        if (b) begin
          if (t >= pr) begin
            t    = t - pr;
            disp = 1'b1;
          end else rej = 1'b1;
        end
        if (cr && (t != 0)) start_return_coin(e, t);
      end else begin
        if (b) rej = 1'b1;
        if (e == m_next_dec) begin
          if (t == 0) m_active = 1'b0;
          else start_return_coin(e, t);
        end
      end
      m_credit = t;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = cv;
    end
    if (m_active && ((e - m_seg_start) < PC))
      rets = (m_denom == VP) ? 3'b100 : (m_denom == VT) ? 3'b010 : 3'b001;
    snap = {m_active, rets, disp, rej, ovf, bad, 8'(m_credit)};
    if (snap !== m_last_snap) begin
      exp_q.push_back({32'(e), snap});
      m_last_snap = snap;
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic step(input logic [2:0] cv, input logic b, input int pr,
                      input logic cr, input logic rs);
    @(negedge CLOCK_50);
    {pentagon, triangle, circle} = cv;
    buy         = b;
    price       = 8'(pr);
    coin_return = cr;
    reset       = rs;
    model_edge(edge_cnt + 1, cv, b, pr, cr, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic insert(input logic [2:0] cv, input int hold);
    for (int i = 0; i < hold; i++) step(cv, 1'b0, 0, 1'b0, 1'b0);
    idle(5);
  endtask

  task automatic buy_item(input int pr);
    step(3'b000, 1'b1, pr, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic wait_quiet();
    int guard;
    guard = 0;
    while (m_active && (guard < 5000)) begin
      idle(1);
      guard++;
    end
    check("return_finishes", 32'(m_active), 32'd0);
    idle(3);
  endtask

  function automatic logic [2:0] one_hot_rand();
    case ($urandom_range(0, 2))
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] bad_vec();
    case ($urandom_range(0, 3))
      0:       return 3'b011;
      1:       return 3'b101;
      2:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [2:0] cv, lvl;
    logic       b, cr, rs;
    int         pr, hold_left, gap_left;

    // Reset for two cycles with random inputs.
    reset       = 1'b1;
    {pentagon, triangle, circle} = 3'($urandom_range(0, 7));
    buy         = 1'($urandom_range(0, 1));
    coin_return = 1'($urandom_range(0, 1));
    price       = 8'($urandom_range(0, 255));
    step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
         1'($urandom_range(0, 1)), 1'b1);
    @(posedge CLOCK_50);
    #1;
    check("reset_credit",   32'(credit),   32'd0);
    check("reset_dispense", 32'(dispense), 32'd0);
    check("reset_reject",   32'(reject),   32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_bad_coin", 32'(bad_coin), 32'd0);
    check("reset_ret",      32'({ret_pentagon, ret_triangle, ret_circle}), 32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    mon_last = 16'h0000;
    mon_en   = 1'b1;

    // Coin counting, including a bad vector and a level change without zero.
    insert(3'b100, 100);
    check("credit_after_pentagon", 32'(credit), 32'd5);
    insert(3'b010, 100);
    check("credit_after_triangle", 32'(credit), 32'd8);
    insert(3'b011, 10);
    check("credit_after_bad_coin", 32'(credit), 32'd8);
    for (int i = 0; i < 4; i++) step(3'b001, 1'b0, 0, 1'b0, 1'b0);
    insert(3'b100, 4);
    check("credit_after_level_change", 32'(credit), 32'd9);
    buy_item(1);

    // Purchase granted then refused.
    buy_item(7);
    check("credit_after_dispense", 32'(credit), 32'd1);
    buy_item(7);
    check("credit_after_reject", 32'(credit), 32'd1);

    // Change return of 9: pentagon, triangle, circle.
    insert(3'b100, 3);
    insert(3'b010, 3);
    check("credit_before_return", 32'(credit), 32'd9);
    step(3'b000, 1'b0, 0, 1'b1, 1'b0);
    wait_quiet();
    check("credit_after_return", 32'(credit), 32'd0);
    check("busy_after_return",   32'(busy),   32'd0);

    // Saturation at the ceiling.
    for (int i = 0; i < 50; i++) insert(3'b100, 3);
    insert(3'b010, 3);
    check("credit_253", 32'(credit), 32'd253);
    insert(3'b100, 3);
    check("credit_saturated", 32'(credit), 32'd255);
    buy_item(250);

    // Return with a buy (rejected even at price 0) and a circle inserted
    // mid-return, which must be appended as an extra circle pulse.
    step(3'b000, 1'b0, 0, 1'b1, 1'b0);
    step(3'b000, 1'b1, 0, 1'b0, 1'b0);
    insert(3'b001, 3);
    wait_quiet();
    check("credit_after_mid_return", 32'(credit), 32'd0);

    // Buy and return in the same cycle at credit 4.
    insert(3'b010, 3);
    insert(3'b001, 3);
    step(3'b000, 1'b1, 3, 1'b1, 1'b0);
    wait_quiet();
    check("credit_after_simultaneous", 32'(credit), 32'd0);

    // Reset while a return pulse is high.
    insert(3'b100, 3);
    step(3'b000, 1'b0, 0, 1'b1, 1'b0);
    idle(1);
    step(3'b000, 1'b0, 0, 1'b0, 1'b1);
    @(posedge CLOCK_50);
    #1;
    check("abort_ret",    32'({ret_pentagon, ret_triangle, ret_circle}), 32'd0);
    check("abort_credit", 32'(credit), 32'd0);
    check("abort_busy",   32'(busy),   32'd0);
    idle(3);

    // Randomised mix of coins, purchases, returns and rare resets.
    hold_left = 0;
    gap_left  = 0;
    lvl       = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left > 0) begin
        hold_left--;
        if ($urandom_range(0, 19) == 0) lvl = one_hot_rand();
        cv = lvl;
        if (hold_left == 0) gap_left = $urandom_range(1, 8);
      end else if (gap_left > 0) begin
        gap_left--;
        cv = 3'b000;
      end else if ($urandom_range(0, 99) < 12) begin
        lvl       = ($urandom_range(0, 9) == 0) ? bad_vec() : one_hot_rand();
        hold_left = $urandom_range(2, 9);
        cv        = lvl;
      end else begin
        cv = 3'b000;
      end
      b  = ($urandom_range(0, 99) < 6);
      pr = $urandom_range(0, 12);
      cr = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 999) == 0);
      step(cv, b, pr, cr, rs);
    end
    idle(2);
    wait_quiet();
    idle(5);

    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_credit_controller.md
# vend_credit_controller

Credit and change-return sequencer for the vending machine. Consumes the circle/triangle/pentagon coin levels produced by the coin accepter, accumulates saturating credit, and arbitrates purchase requests against that credit. On request, it pays the credit back as a timed sequence of coin-return pulses.

## Interface
Parameters:
- CREDIT_W, 8: credit register width.
- MAX_CREDIT, 255: saturation ceiling, ≤ 2^CREDIT_W−1.
- VAL_CIRCLE, 1: circle value. Must be 1 so change return always terminates.
- VAL_TRIANGLE, 3: triangle value.
- VAL_PENTAGON, 5: pentagon value.
- PULSE_CYCLES, 25_000_000: length of each return pulse (≥1).
- GAP_CYCLES, 25_000_000: low time after each return pulse (≥1).

Ports:
- CLOCK_50 in 1: system clock; all state is on its rising edge.
- reset in 1: synchronous, active-high.
- circle, triangle, pentagon in 1 each: coin levels, asynchronous to CLOCK_50, each held for many cycles.
- buy in 1: one-cycle purchase request.
- price in CREDIT_W: item price, sampled together with buy.
- coin_return in 1: one-cycle change-return request.
- credit out CREDIT_W: current credit.
- dispense out 1: one-cycle pulse, purchase granted.
- reject out 1: one-cycle pulse, purchase refused.
- overflow out 1: one-cycle pulse, coin value clipped by saturation.
- bad_coin out 1: one-cycle pulse, non-one-hot coin vector.
- ret_circle, ret_triangle, ret_pentagon out 1 each: change-return drive.
- busy out 1: high whenever the controller is not in IDLE.

## Operation
**Coin input path**
- The 3-bit coin vector passes through a 2-flop synchronizer, then a registered previous copy.
- A coin event occurs when the synchronized vector is nonzero and the previous copy is zero. One event is counted per level episode.
- Value changes between nonzero vectors without returning to zero are ignored.
- If the vector at the event is not one-hot, bad_coin pulses and credit is unchanged.
- Coin events are accepted in every state.

**Credit arithmetic**
- Let sum = credit + coin value, computed at CREDIT_W+1 bits.
- t = min(sum, MAX_CREDIT). overflow pulses if sum > MAX_CREDIT.

**States: IDLE, RET_PULSE, RET_GAP**

IDLE:
- With buy: if t ≥ price, credit ← t − price and dispense pulses. Otherwise credit ← t and reject pulses. price = 0 always grants.
- With coin_return: if the post-buy credit is 0, there is no effect. Otherwise go to RET_PULSE.
- buy and coin_return in the same cycle: the buy is resolved first, and the return uses the remaining credit.

Entering RET_PULSE:
- Choose the denomination greedily: the largest of pentagon, triangle, circle whose value ≤ the entering credit.
- Subtract that value in the same cycle as any coin add. The subtraction cannot underflow.
- Load the pulse counter.

RET_PULSE:
- The selected ret_* output is high for exactly PULSE_CYCLES cycles, then go to RET_GAP.

RET_GAP:
- All ret_* outputs are low for GAP_CYCLES cycles.
- Then, if credit = 0, go to IDLE. Otherwise re-enter RET_PULSE with a new greedy choice on live credit, so coins inserted mid-return are also returned.

Outside IDLE:
- buy gives a reject pulse with credit unchanged.
- coin_return is ignored.

**Output rules**
- At most one ret_* output is high at a time.
- ret_* outputs are registered and glitch-free.

## Timing
**Reset**
- All state is cleared: credit = 0 and all pulse outputs, ret_* and busy are 0. Synchronizer and previous-copy flops are 0.
- Reset in RET_* states aborts the return. Unreturned credit is discarded.

**Coin latency**
- A coin level first sampled at edge N updates credit at edge N+2.
- overflow and bad_coin are high in the cycle after edge N+2.

**Buy latency**
- buy sampled at edge N: credit updates at edge N.
- dispense or reject is high for exactly the one cycle following edge N.

**Return latency**
- coin_return sampled at edge N: the first ret_* output and busy rise after edge N.
- Each pulse lasts PULSE_CYCLES cycles, followed by GAP_CYCLES low cycles.
- busy falls with the last gap's expiry, after (PULSE_CYCLES + GAP_CYCLES) × pulse-count cycles.

## Test plan
For tests 4–6, PULSE_CYCLES = 4 and GAP_CYCLES = 2.

1. **Reset:** assert reset for 2 cycles with random inputs → credit = 0; all outputs 0; busy = 0.
2. **Coin counting:** hold pentagon 100 cycles, release, then hold triangle 100 cycles → credit 5 then 8, each counted once at edge+2. Assert circle and triangle together → bad_coin pulse, credit unchanged.
3. **Purchase:** credit 8, buy with price = 7 → dispense one cycle, credit 1. Repeat buy with price = 7 → reject, credit stays 1.
4. **Change return:** credit 9, coin_return → ret_pentagon 4 cycles, 2 low, ret_triangle 4, 2 low, ret_circle 4, 2 low → credit 0, busy falls after 18 cycles.
5. **Saturation and mid-return events:** credit 253, insert pentagon → credit 255, one overflow pulse. During a return, insert circle → an extra ret_circle pulse is appended. buy during the return → reject, credit unchanged.
6. **Simultaneous and abort cases:** buy with price = 3 and coin_return in the same cycle at credit 4 → dispense, then a single ret_circle. reset asserted mid-RET_PULSE → ret_* low and credit = 0 on the next cycle.
